proc_n: RTL and testbench
=========================

// Module: proc_n
// PURPOSE
//  Parametrised multi-cycle processor for the DE2 lab top levels: NUM_REGS general registers, DATA_W datapath.
//  - Fetches an instruction word from DIN when Run is high, then executes it in 1 to 3 further steps over a single shared bus.
//  - Extends the fixed 16-bit/8-register processor with:
//    - generic width and register count;
//    - logic ops (and, or, xor);
//    - conditional move (mvnz).
//  - Top level drives DIN/Run from switches, Clock/Resetn from keys; shows BusWires on LEDs/HEX and Done on LEDG.
// PARAMETERS
//  DATA_W    16  datapath, register and bus width; must be >= IR_W
//  NUM_REGS  8   number of general registers R0..R(NUM_REGS-1); power of 2, >= 2
//  REG_AW    $clog2(NUM_REGS)  localparam, register-field width
//  IR_W      3+2*REG_AW        localparam, instruction width, taken from DIN[IR_W-1:0]
// PORTS
//  Clock     in   1       single clock, rising edge
//  Resetn    in   1       synchronous active-low reset
//  DIN       in   DATA_W  instruction word (T0) or immediate (mvi, T1)
//  Run       in   1       start: sampled only in step T0
//  Done      out  1       high for exactly the final step of each instruction
//  BusWires  out  DATA_W  shared bus value (observable)
// BEHAVIOUR
//  - Instruction format: IR = {op[2:0], X[REG_AW-1:0], Y[REG_AW-1:0]}; Rx/Ry are the selected registers.
//  - Opcodes:
//    - 000 mv Rx,Ry
//    - 001 mvi Rx,#D
//    - 010 add
//    - 011 sub
//    - 100 and
//    - 101 or
//    - 110 xor
//    - 111 mvnz Rx,Ry
//  - Step FSM T0->T1->T2->T3, 2-bit state, reset state T0:
//    - T0: if Run, IR<=DIN[IR_W-1:0] and go T1; else hold T0. Bus = 0, Done = 0.
//    - T1 mv: bus=Ry, Rx<=bus, Done=1, ->T0.
//    - T1 mvi: bus=DIN, Rx<=bus, Done=1, ->T0.
//    - T1 mvnz: bus=Ry; Rx<=bus only if G!=0; Done=1; ->T0.
//    - T1 ALU ops: bus=Rx, A<=bus, ->T2.
//    - T2 ALU ops: bus=Ry, G<=A op bus, ->T3.
//    - T3 ALU ops: bus=G, Rx<=bus, Done=1, ->T0.
//  - Latency counted from the T0 fetch edge: mv/mvi/mvnz Done in the next cycle; ALU ops Done 3 cycles after fetch.
//  - Arithmetic: add/sub are modulo 2^DATA_W; no carry or overflow flags. sub = A - Ry.
//  - G is written only by ALU ops; mvnz tests the G value left by the last ALU op.
//  - Bus mux: exactly one source per step (DIN, R0..Rn-1, G); BusWires=0 when no source (T0). Combinational from state/IR.
//  - Done is combinational from state and IR; glitch-free at the register edge.
//  - Run is ignored outside T0. Holding Run high chains instructions back to back: a new fetch occurs in the cycle after Done.
//  - X==Y is legal:
//    - add R0,R0 doubles R0;
//    - sub Rx,Rx gives 0 and sets G=0.
//  - Reset, Resetn low at a rising edge, at any step including mid-instruction:
//    - state->T0, all R, A, G, IR -> 0;
//    - Done=0, BusWires=0 in the following cycle;
//    - a partially executed instruction is abandoned with no register write.
//  - DIN bits above IR_W are ignored during fetch; full DATA_W bits are used for mvi.
// STRUCTURE
//  - Package proc_n_pkg:
//    - opcode localparams OP_MV..OP_MVNZ;
//    - step encodings T0..T3;
//    - bus-select encoding SEL_NONE, SEL_DIN, SEL_G, SEL_REG.
//  - Sub-module regn #(W): W-bit register with enable and sync active-low clear. Instantiated for R[], A, G and IR via generate.
//  - ALU, control FSM and bus mux are inline in proc_n.
// TESTING  (DATA_W=16, NUM_REGS=8; IR in DIN[8:0])
//  - mvi: DIN=0x040 (mvi R0) with Run, then DIN=0x0005 -> T1 BusWires=0x0005, Done=1, R0=5.
//  - mv, add: mv R1,R0 (0x008), then add R0,R1 (0x081) -> Done in T3 only, BusWires=0x000A, R0=10, R1=5.
//  - sub wrap: R1=5, R0=10; sub R1,R0 (0x0C8) -> R1=0xFFFB, G=0xFFFB.
//  - mvnz:
//    - after sub R0,R0 (0x0C0) makes G=0, mvnz R2,R1 (0x1D1) leaves R2 unchanged with Done=1;
//    - after add making G=0x000A, the same mvnz writes R2=R1.
//  - Reset mid-instruction: Resetn=0 during T2 of add -> next cycle state T0, Done=0, BusWires=0, all registers 0; target unchanged.
//  - Run idle/chaining:
//    - Run=0 holds T0 for 10 cycles with no writes;
//    - Run held high chains mvi, mvi, xor (0x181) back to back with Done pulses at the expected cycles;
//    - repeat all scenarios with DATA_W=12, NUM_REGS=4.

Source files
------------

// File: rtl/proc_n_pkg.sv
// Shared encodings for the proc_n multi-cycle processor: opcodes, step states
// and bus-source selects.
package proc_n_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DIN  = 2'd1,
        SEL_G    = 2'd2,
        SEL_REG  = 2'd3
    } bus_sel_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/proc_n_regn.sv
// W-bit storage register with load enable and synchronous active-low clear.
// Used for the general registers, the ALU operand A, the result G and the IR.
module regn #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/proc_n.sv
// Multi-cycle processor: NUM_REGS registers of DATA_W bits sharing one bus,
// one instruction fetched from DIN per Run, executed in 1 to 3 further steps.
//
// state | meaning
// T0    | idle / fetch: IR <= DIN when Run, bus idle
// T1    | mv/mvi/mvnz complete here; ALU ops latch Rx into A
// T2    | ALU op: G <= A op Ry
// T3    | ALU op: Rx <= G, instruction complete
module proc_n
    import proc_n_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Run,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires
);

    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int IR_W   = 3 + 2 * REG_AW;

    step_t               step_q;
    step_t               step_d;
    bus_sel_t            bus_sel;
    logic [REG_AW-1:0]   reg_sel;

    logic [IR_W-1:0]     ir_q;
    logic                ir_en;
    logic [2:0]          op;
    logic [REG_AW-1:0]   rx;
    logic [REG_AW-1:0]   ry;

    logic [DATA_W-1:0]   r_q [NUM_REGS];
    logic [NUM_REGS-1:0] r_en;
    logic                rx_wr;

    logic [DATA_W-1:0]   a_q;
    logic                a_en;
    logic [DATA_W-1:0]   g_q;
    logic                g_en;
    logic [DATA_W-1:0]   alu_y;

    assign op = ir_q[IR_W-1 -: 3];
    assign rx = ir_q[2*REG_AW-1 -: REG_AW];
    assign ry = ir_q[REG_AW-1:0];

    // ---------------- storage ----------------
    regn #(.W(IR_W)) u_ir (
        .clock   (Clock),
        .clear_n (Resetn),
        .en      (ir_en),
        .d       (DIN[IR_W-1:0]),
        .q       (ir_q)
    );

    regn #(.W(DATA_W)) u_a (
        .clock   (Clock),
        .clear_n (Resetn),
        .en      (a_en),
        .d       (BusWires),
        .q       (a_q)
    );

    regn #(.W(DATA_W)) u_g (
        .clock   (Clock),
        .clear_n (Resetn),
        .en      (g_en),
        .d       (alu_y),
        .q       (g_q)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign r_en[i] = rx_wr && (rx == REG_AW'(i));

        regn #(.W(DATA_W)) u_r (
            .clock   (Clock),
            .clear_n (Resetn),
            .en      (r_en[i]),
            .d       (BusWires),
            .q       (r_q[i])
        );
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    always_comb begin
        step_d  = step_q;
        bus_sel = SEL_NONE;
        reg_sel = '0;
        ir_en   = 1'b0;
        a_en    = 1'b0;
        g_en    = 1'b0;
        rx_wr   = 1'b0;
        Done    = 1'b0;

        case (step_q)
            T0: begin
                if (Run) begin
                    ir_en  = 1'b1;
                    step_d = T1;
                end
            end

            T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel = SEL_REG;
                        reg_sel = ry;
                        rx_wr   = 1'b1;
                        Done    = 1'b1;
                        step_d  = T0;
                    end
                    OP_MVI: begin
                        bus_sel = SEL_DIN;
                        rx_wr   = 1'b1;
                        Done    = 1'b1;
                        step_d  = T0;
                    end
                    OP_MVNZ: begin
                        // Condition is the G left behind by the most recent ALU op.
                        bus_sel = SEL_REG;
                        reg_sel = ry;
                        rx_wr   = (g_q != '0);
                        Done    = 1'b1;
                        step_d  = T0;
                    end
                    default: begin
                        bus_sel = SEL_REG;
                        reg_sel = rx;
                        a_en    = 1'b1;
                        step_d  = T2;
                    end
                endcase
            end

            T2: begin
                if (is_alu_op(op)) begin
                    bus_sel = SEL_REG;
                    reg_sel = ry;
                    g_en    = 1'b1;
                    step_d  = T3;
                end else begin
                    step_d  = T0;
                end
            end

            T3: begin
                if (is_alu_op(op)) begin
                    bus_sel = SEL_G;
                    rx_wr   = 1'b1;
                    Done    = 1'b1;
                end
                step_d = T0;
            end

            default: step_d = T0;
        endcase
    end

    // ---------------- ALU ----------------
    always_comb begin
        alu_y = '0;
        case (op)
            OP_ADD:  alu_y = a_q + BusWires;
            OP_SUB:  alu_y = a_q - BusWires;
            OP_AND:  alu_y = a_q & BusWires;
            OP_OR:   alu_y = a_q | BusWires;
            OP_XOR:  alu_y = a_q ^ BusWires;
            default: alu_y = '0;
        endcase
    end

    // ---------------- bus mux ----------------
    always_comb begin
        BusWires = '0;
        case (bus_sel)
            SEL_DIN:  BusWires = DIN;
            SEL_G:    BusWires = g_q;
            SEL_REG:  BusWires = r_q[reg_sel];
            default:  BusWires = '0;
        endcase
    end

endmodule

// File: tb/tb_proc_n.sv
// Directed bench for proc_n: a 16-bit/8-register and a 12-bit/4-register
// instance run the same program in lockstep and are checked on Done/BusWires.
module tb_proc_n;
    import proc_n_pkg::*;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [15:0] din16;
    logic [11:0] din12;
    logic        done16;
    logic        done12;
    logic [15:0] bus16;
    logic [11:0] bus12;

    int n_checks = 0;
    int n_fail   = 0;

    proc_n #(.DATA_W(16), .NUM_REGS(8)) dut16 (
        .Clock    (clk),
        .Resetn   (resetn),
        .DIN      (din16),
        .Run      (run),
        .Done     (done16),
        .BusWires (bus16)
    );

    proc_n #(.DATA_W(12), .NUM_REGS(4)) dut12 (
        .Clock    (clk),
        .Resetn   (resetn),
        .DIN      (din12),
        .Run      (run),
        .Done     (done12),
        .BusWires (bus12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        int          x;
        int          y;
        logic [15:0] imm;
        bit          junk;
        int          cyc;
        logic [15:0] e16;
        logic [11:0] e12;
    } instr_vec_t;

    typedef struct {
        bit          run;
        logic [15:0] din16;
        logic [11:0] din12;
        bit          e_done;
        logic [15:0] e_bus;
    } cycle_vec_t;

    instr_vec_t vec [21];
    cycle_vec_t chain [9];

    function automatic logic [15:0] enc16(input logic [2:0] op, input int x, input int y);
        logic [2:0] xv;
        logic [2:0] yv;
        xv = 3'(x);
        yv = 3'(y);
        return {7'd0, op, xv, yv};
    endfunction

    function automatic logic [11:0] enc12(input logic [2:0] op, input int x, input int y);
        logic [1:0] xv;
        logic [1:0] yv;
        xv = 2'(x);
        yv = 2'(y);
        return {5'd0, op, xv, yv};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm, input int idx);
        chk({nm, "_done16"}, idx, {15'd0, done16}, 16'd0);
        chk({nm, "_bus16"},  idx, bus16, 16'd0);
        chk({nm, "_done12"}, idx, {15'd0, done12}, 16'd0);
        chk({nm, "_bus12"},  idx, {4'd0, bus12}, 16'd0);
    endtask

    // Called at a falling edge with both DUTs in T0; returns at a falling edge in T0.
    task automatic do_instr(input logic [2:0] op, input int x, input int y,
                            input logic [15:0] imm, input bit junk, input int cyc_exp,
                            input logic [15:0] e16, input logic [11:0] e12, input int idx);
        int cyc;
        din16 = enc16(op, x, y) | (junk ? 16'hFE00 : 16'h0000);
        din12 = enc12(op, x, y) | (junk ? 12'hF80 : 12'h000);
        run   = 1'b1;
        #1;
        chk("t0_done", idx, {15'd0, done16}, 16'd0);
        chk("t0_bus",  idx, bus16, 16'd0);
        @(negedge clk);
        run   = 1'b0;
        din16 = imm;
        din12 = imm[11:0];
        #1;
        cyc = 1;
        while (!done16 && cyc < 4) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("latency", idx, 16'(cyc), 16'(cyc_exp));
        chk("done12",  idx, {15'd0, done12}, 16'd1);
        chk("bus16",   idx, bus16, e16);
        chk("bus12",   idx, {4'd0, bus12}, {4'd0, e12});
        @(negedge clk);
    endtask

    initial begin
        vec[0]  = '{OP_MVI,  0, 0, 16'h0005, 1'b0, 1, 16'h0005, 12'h005};
        vec[1]  = '{OP_MV,   1, 0, 16'h0000, 1'b0, 1, 16'h0005, 12'h005};
        vec[2]  = '{OP_ADD,  0, 1, 16'h0000, 1'b0, 3, 16'h000A, 12'h00A};
        vec[3]  = '{OP_MV,   0, 0, 16'h0000, 1'b0, 1, 16'h000A, 12'h00A};
        vec[4]  = '{OP_MV,   1, 1, 16'h0000, 1'b0, 1, 16'h0005, 12'h005};
        vec[5]  = '{OP_SUB,  1, 0, 16'h0000, 1'b0, 3, 16'hFFFB, 12'hFFB};
        vec[6]  = '{OP_SUB,  0, 0, 16'h0000, 1'b0, 3, 16'h0000, 12'h000};
        vec[7]  = '{OP_MVNZ, 2, 1, 16'h0000, 1'b0, 1, 16'hFFFB, 12'hFFB};
        vec[8]  = '{OP_MV,   2, 2, 16'h0000, 1'b0, 1, 16'h0000, 12'h000};
        vec[9]  = '{OP_MVI,  0, 0, 16'h000A, 1'b0, 1, 16'h000A, 12'h00A};
        vec[10] = '{OP_ADD,  0, 3, 16'h0000, 1'b0, 3, 16'h000A, 12'h00A};
        vec[11] = '{OP_MVNZ, 2, 1, 16'h0000, 1'b0, 1, 16'hFFFB, 12'hFFB};
        vec[12] = '{OP_MV,   2, 2, 16'h0000, 1'b0, 1, 16'hFFFB, 12'hFFB};
        vec[13] = '{OP_MVI,  3, 0, 16'h0F0F, 1'b0, 1, 16'h0F0F, 12'hF0F};
        vec[14] = '{OP_AND,  3, 1, 16'h0000, 1'b0, 3, 16'h0F0B, 12'hF0B};
        vec[15] = '{OP_XOR,  3, 0, 16'h0000, 1'b0, 3, 16'h0F01, 12'hF01};
        vec[16] = '{OP_OR,   3, 0, 16'h0000, 1'b0, 3, 16'h0F0B, 12'hF0B};
        vec[17] = '{OP_MVI,  0, 0, 16'hABCD, 1'b0, 1, 16'hABCD, 12'hBCD};
        vec[18] = '{OP_ADD,  0, 0, 16'h0000, 1'b0, 3, 16'h579A, 12'h79A};
        vec[19] = '{OP_MV,   1, 0, 16'h0000, 1'b1, 1, 16'h579A, 12'h79A};
        vec[20] = '{OP_MV,   1, 1, 16'h0000, 1'b0, 1, 16'h579A, 12'h79A};

        // Run held high: mvi R0,#3; mvi R1,#6; xor R0,R1 back to back.
        chain[0] = '{1'b1, enc16(OP_MVI, 0, 0), enc12(OP_MVI, 0, 0), 1'b0, 16'h0000};
        chain[1] = '{1'b1, 16'h0003,            12'h003,             1'b1, 16'h0003};
        chain[2] = '{1'b1, enc16(OP_MVI, 1, 0), enc12(OP_MVI, 1, 0), 1'b0, 16'h0000};
        chain[3] = '{1'b1, 16'h0006,            12'h006,             1'b1, 16'h0006};
        chain[4] = '{1'b1, enc16(OP_XOR, 0, 1), enc12(OP_XOR, 0, 1), 1'b0, 16'h0000};
        chain[5] = '{1'b1, enc16(OP_MVI, 2, 0), enc12(OP_MVI, 2, 0), 1'b0, 16'h0003};
        chain[6] = '{1'b1, enc16(OP_MVI, 3, 0), enc12(OP_MVI, 3, 0), 1'b0, 16'h0006};
        chain[7] = '{1'b1, enc16(OP_MVI, 2, 0), enc12(OP_MVI, 2, 0), 1'b1, 16'h0005};
        chain[8] = '{1'b0, 16'h0000,            12'h000,             1'b0, 16'h0000};

        resetn = 1'b0;
        run    = 1'b0;
        din16  = '0;
        din12  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset", 0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            do_instr(OP_MV, i, i, 16'h0000, 1'b0, 1, 16'h0000, 12'h000, 100 + i);
        end

        for (int i = 0; i < 21; i++) begin
            do_instr(vec[i].op, vec[i].x, vec[i].y, vec[i].imm, vec[i].junk,
                     vec[i].cyc, vec[i].e16, vec[i].e12, i);
        end

        for (int k = 0; k < 9; k++) begin
            run   = chain[k].run;
            din16 = chain[k].din16;
            din12 = chain[k].din12;
            #1;
            chk("chain_done16", k, {15'd0, done16}, {15'd0, chain[k].e_done});
            chk("chain_bus16",  k, bus16, chain[k].e_bus);
            chk("chain_done12", k, {15'd0, done12}, {15'd0, chain[k].e_done});
            chk("chain_bus12",  k, {4'd0, bus12}, chain[k].e_bus);
            @(negedge clk);
        end

        run   = 1'b0;
        din16 = enc16(OP_MVI, 0, 0);
        din12 = enc12(OP_MVI, 0, 0);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk_idle("idle", k);
            @(negedge clk);
        end
        do_instr(OP_MV, 0, 0, 16'h0000, 1'b0, 1, 16'h0005, 12'h005, 200);
        do_instr(OP_MV, 1, 1, 16'h0000, 1'b0, 1, 16'h0006, 12'h006, 201);

        // Reset during T2 of add R0,R1: the write to R0 must never happen.
        run   = 1'b1;
        din16 = enc16(OP_ADD, 0, 1);
        din12 = enc12(OP_ADD, 0, 1);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_t2_bus16", 0, bus16, 16'h0006);
        @(negedge clk);
        #1;
        chk_idle("mid_reset", 0);
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_instr(OP_MV, i, i, 16'h0000, 1'b0, 1, 16'h0000, 12'h000, 300 + i);
        end
        // G was cleared too, so mvnz must not copy R3 into R2.
        do_instr(OP_MVI,  3, 0, 16'h0007, 1'b0, 1, 16'h0007, 12'h007, 310);
        do_instr(OP_MVNZ, 2, 3, 16'h0000, 1'b0, 1, 16'h0007, 12'h007, 311);
        do_instr(OP_MV,   2, 2, 16'h0000, 1'b0, 1, 16'h0000, 12'h000, 312);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
